// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, opcode
// encodings and default widths.
package fetch_pkg;

  localparam int PCW_DEF  = 10;
  localparam int IW_DEF   = 9;
  localparam int CNTW_DEF = 16;
  localparam int LUT_N    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [3:0] OP_JMP  = 4'b0000;
  localparam logic [3:0] OP_BEQ  = 4'b0001;
  localparam logic [3:0] OP_BNE  = 4'b0010;
  localparam logic [3:0] OP_BLT  = 4'b0011;
  localparam logic [3:0] OP_BGT  = 4'b0100;
  localparam logic [3:0] OP_HALT = 4'b1111;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle between the fetch sequencer and its surroundings (imem, decoder,
// compare flags, program handshake); slave is the sequencer side.
interface fetch_ctrl_if
  import fetch_pkg::*;
#(
  parameter int PCW  = PCW_DEF,
  parameter int IW   = IW_DEF,
  parameter int CNTW = CNTW_DEF
);

  logic            start;
  logic            stall;
  logic [IW-1:0]   instr;
  logic            uncond_jump;
  logic            jtype;
  logic            flag_eq;
  logic            flag_lt;
  logic            flag_gt;
  logic [PCW-1:0]  pc;
  logic            done;
  logic            running;
  logic [CNTW-1:0] cycle_cnt;

  modport master (
    output start, stall, instr, uncond_jump, jtype, flag_eq, flag_lt, flag_gt,
    input  pc, done, running, cycle_cnt
  );

  modport slave (
    input  start, stall, instr, uncond_jump, jtype, flag_eq, flag_lt, flag_gt,
    output pc, done, running, cycle_cnt
  );

endinterface

// File: rtl/fetch_ctrl_jump_lut.sv
// Absolute jump-target table, 32 entries indexed by instr[4:0]; purely
// combinational, regenerated by the assembler flow when the map changes.
module jump_lut
  import fetch_pkg::*;
#(
  parameter int PCW = PCW_DEF
) (
  input  logic [4:0]     idx,
  output logic [PCW-1:0] target
);

  logic [PCW-1:0] lut [LUT_N];

  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    assign lut[g] = PCW'(g * 10);
  end

  assign target = lut[idx];

endmodule

// File: rtl/fetch_ctrl.sv
// PC / fetch sequencer: IDLE-RUN-HALT FSM, next-PC select, cycle counter.
// Next PC lands one edge after instr is seen; stall freezes all RUN state.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PCW  = PCW_DEF,
  parameter int IW   = IW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  fetch_ctrl_if.slave bus
);

  state_t          state;
  logic [PCW-1:0]  pc_q;
  logic            done_q;
  logic            running_q;
  logic [CNTW-1:0] cnt_q;

  logic [3:0]      opcode;
  logic [PCW-1:0]  lut_target;
  logic [PCW-1:0]  next_pc;
  logic            cond;
  logic            taken;

  assign opcode = bus.instr[IW-1:IW-4];

  jump_lut #(.PCW(PCW)) u_jump_lut (
    .idx    (bus.instr[4:0]),
    .target (lut_target)
  );

  always_comb begin
    cond = 1'b0;
    case (opcode)
      OP_BEQ:  cond = bus.flag_eq;
      OP_BNE:  cond = !bus.flag_eq;
      OP_BLT:  cond = bus.flag_lt;
      OP_BGT:  cond = bus.flag_gt;
      default: cond = 1'b0;
    endcase
  end

  assign taken   = bus.uncond_jump | (bus.jtype & cond);
  assign next_pc = taken ? lut_target : pc_q + PCW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc_q      <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (bus.start) begin
            state     <= RUN;
            pc_q      <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.stall) begin
            if (cnt_q != '1)
              cnt_q <= cnt_q + CNTW'(1);
            // HALT keeps pc on the halt instruction so it is visible while done
            if (opcode == OP_HALT) begin
              state     <= HALT;
              done_q    <= 1'b1;
              running_q <= 1'b0;
            end else begin
              pc_q <= next_pc;
            end
          end
        end
        default: begin
          state     <= IDLE;
          pc_q      <= '0;
          done_q    <= 1'b0;
          running_q <= 1'b0;
          cnt_q     <= '0;
        end
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.done      = done_q;
  assign bus.running   = running_q;
  assign bus.cycle_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a bench-side imem and decoder feed instr and
// jump strobes from the DUT's pc; each task checks its own scenario.
module tb_fetch_ctrl;

  localparam int PCW  = 10;
  localparam int IW   = 9;
  localparam int CNTW = 16;
  localparam logic [8:0] ALU  = 9'b0101_00000;
  localparam logic [8:0] HLT  = 9'b1111_00000;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [8:0] imem [1024];
  logic       ovr_en;
  logic [8:0] ovr_instr;
  logic       force_jtype;
  logic [3:0] op;

  fetch_ctrl_if #(.PCW(PCW), .IW(IW), .CNTW(CNTW)) bus ();

  fetch_ctrl #(.PCW(PCW), .IW(IW), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.instr       = ovr_en ? ovr_instr : imem[bus.pc];
  assign op              = bus.instr[8:5];
  assign bus.uncond_jump = (op == 4'b0000);
  assign bus.jtype       = (op >= 4'd1 && op <= 4'd4) || force_jtype;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hard_reset();
    reset = 1'b1; bus.start = 1'b0; bus.stall = 1'b0; ovr_en = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ovr_en = 1'b1;
    bus.start = 1'($urandom_range(0, 1)); ovr_instr = 9'($urandom);
    tick();
    bus.start = 1'($urandom_range(0, 1)); ovr_instr = 9'($urandom);
    tick();
    checks++; if (bus.pc !== 10'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", bus.pc); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b expected 0", bus.running); end
    checks++; if (bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.cycle_cnt); end
    reset = 1'b0; bus.start = 1'b0; ovr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.pc !== 10'd0 || bus.running !== 1'b0) begin errors++; $display("FAIL idle_hold[%0d]: got pc=%0d running=%0b expected pc=0 running=0", i, bus.pc, bus.running); end
    end
  endtask

  task automatic test_linear();
    hard_reset();
    start_pulse();
    checks++; if (bus.pc !== 10'd0 || bus.running !== 1'b1 || bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL start_entry: got pc=%0d running=%0b cnt=%0d expected pc=0 running=1 cnt=0", bus.pc, bus.running, bus.cycle_cnt); end
    for (int i = 1; i <= 5; i++) begin
      bus.start = (i == 3);  // start during RUN must not restart
      tick();
      bus.start = 1'b0;
      checks++; if (bus.pc !== 10'(i)) begin errors++; $display("FAIL linear_pc[%0d]: got %0d expected %0d", i, bus.pc, i); end
    end
    checks++; if (bus.cycle_cnt !== 16'd5) begin errors++; $display("FAIL linear_cnt: got %0d expected 5", bus.cycle_cnt); end
  endtask

  task automatic test_uncond();
    hard_reset();
    imem[2] = {4'b0000, 5'd3};
    start_pulse();
    tick(2);
    checks++; if (bus.pc !== 10'd2) begin errors++; $display("FAIL jmp_pre: got %0d expected 2", bus.pc); end
    tick();
    checks++; if (bus.pc !== 10'd30) begin errors++; $display("FAIL jmp_target: got %0d expected 30", bus.pc); end
    tick();
    checks++; if (bus.pc !== 10'd31) begin errors++; $display("FAIL jmp_after: got %0d expected 31", bus.pc); end
    imem[2] = ALU;
  endtask

  task automatic test_cond();
    int op_t  [10] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 0};
    int idx_t [10] = '{1, 1, 2, 2, 4, 4, 5, 5, 7, 31};
    int eq_t  [10] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    int lt_t  [10] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 0};
    int gt_t  [10] = '{0, 0, 0, 0, 0, 1, 1, 0, 1, 0};
    int fj_t  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int exp_t [10] = '{1, 10, 1, 20, 40, 1, 50, 1, 1, 310};
    for (int i = 0; i < 10; i++) begin
      hard_reset();
      imem[0]     = {4'(op_t[i]), 5'(idx_t[i])};
      bus.flag_eq = 1'(eq_t[i]);
      bus.flag_lt = 1'(lt_t[i]);
      bus.flag_gt = 1'(gt_t[i]);
      force_jtype = 1'(fj_t[i]);
      start_pulse();
      tick();
      checks++; if (bus.pc !== 10'(exp_t[i])) begin errors++; $display("FAIL cond[%0d] op=%0d: got pc=%0d expected %0d", i, op_t[i], bus.pc, exp_t[i]); end
      imem[0] = ALU; force_jtype = 1'b0;
      bus.flag_eq = 1'b0; bus.flag_lt = 1'b0; bus.flag_gt = 1'b0;
    end
  endtask

  task automatic test_halt();
    hard_reset();
    imem[7] = HLT;
    start_pulse();
    tick(7);
    checks++; if (bus.pc !== 10'd7 || bus.done !== 1'b0) begin errors++; $display("FAIL halt_fetch: got pc=%0d done=%0b expected pc=7 done=0", bus.pc, bus.done); end
    tick();
    checks++; if (bus.done !== 1'b1 || bus.pc !== 10'd7 || bus.running !== 1'b0) begin errors++; $display("FAIL halt_enter: got done=%0b pc=%0d running=%0b expected 1 7 0", bus.done, bus.pc, bus.running); end
    checks++; if (bus.cycle_cnt !== 16'd8) begin errors++; $display("FAIL halt_cnt: got %0d expected 8", bus.cycle_cnt); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.cycle_cnt !== 16'd8 || bus.pc !== 10'd7 || bus.done !== 1'b1) begin errors++; $display("FAIL halt_frozen[%0d]: got cnt=%0d pc=%0d done=%0b expected 8 7 1", i, bus.cycle_cnt, bus.pc, bus.done); end
    end
    start_pulse();
    checks++; if (bus.pc !== 10'd0 || bus.done !== 1'b0 || bus.running !== 1'b1 || bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL restart: got pc=%0d done=%0b running=%0b cnt=%0d expected 0 0 1 0", bus.pc, bus.done, bus.running, bus.cycle_cnt); end
    imem[7] = ALU;
  endtask

  task automatic test_stall();
    hard_reset();
    imem[2] = HLT;
    start_pulse();
    tick(2);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.pc !== 10'd2 || bus.done !== 1'b0 || bus.cycle_cnt !== 16'd2) begin errors++; $display("FAIL stall_hold[%0d]: got pc=%0d done=%0b cnt=%0d expected 2 0 2", i, bus.pc, bus.done, bus.cycle_cnt); end
    end
    bus.stall = 1'b0;
    tick();
    checks++; if (bus.done !== 1'b1 || bus.pc !== 10'd2 || bus.cycle_cnt !== 16'd3) begin errors++; $display("FAIL stall_release: got done=%0b pc=%0d cnt=%0d expected 1 2 3", bus.done, bus.pc, bus.cycle_cnt); end
    imem[2] = ALU;
  endtask

  task automatic test_wrap();
    hard_reset();
    start_pulse();
    tick(1023);
    checks++; if (bus.pc !== 10'd1023 || bus.cycle_cnt !== 16'd1023) begin errors++; $display("FAIL wrap_top: got pc=%0d cnt=%0d expected 1023 1023", bus.pc, bus.cycle_cnt); end
    tick();
    checks++; if (bus.pc !== 10'd0 || bus.cycle_cnt !== 16'd1024) begin errors++; $display("FAIL wrap_zero: got pc=%0d cnt=%0d expected 0 1024", bus.pc, bus.cycle_cnt); end
  endtask

  task automatic test_reset_mid();
    hard_reset();
    start_pulse();
    tick(12);
    checks++; if (bus.pc !== 10'd12) begin errors++; $display("FAIL mid_pre: got %0d expected 12", bus.pc); end
    reset = 1'b1; bus.start = 1'b1;
    tick();
    checks++; if (bus.pc !== 10'd0 || bus.running !== 1'b0 || bus.done !== 1'b0 || bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset: got pc=%0d running=%0b done=%0b cnt=%0d expected 0 0 0 0", bus.pc, bus.running, bus.done, bus.cycle_cnt); end
    reset = 1'b0; bus.start = 1'b0;
    tick();
    checks++; if (bus.running !== 1'b0 || bus.pc !== 10'd0) begin errors++; $display("FAIL mid_idle: got running=%0b pc=%0d expected 0 0", bus.running, bus.pc); end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; ovr_en = 1'b0; ovr_instr = '0; force_jtype = 1'b0;
    bus.start = 1'b0; bus.stall = 1'b0;
    bus.flag_eq = 1'b0; bus.flag_lt = 1'b0; bus.flag_gt = 1'b0;
    for (int i = 0; i < 1024; i++) imem[i] = ALU;
    test_reset();
    test_linear();
    test_uncond();
    test_cond();
    test_halt();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-counter and instruction-fetch sequencer for the 9-bit ISA core. Sits upstream of the control decoder:
- Holds the PC and presents it to instruction memory.
- Consumes the decoder's jump outputs and the compare flags to choose the next PC.
- Runs the start/done program handshake with the testbench/top level.

Jump targets are absolute and come from a 32-entry lookup table indexed by the instruction's low 5 bits.

## Interface
- PCW, 10, program counter width (instruction memory depth 2^PCW)
- IW, 9, instruction width; opcode = instr[IW-1:IW-4], LUT index = instr[4:0]
- CNTW, 16, cycle counter width

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; overrides every other input
- start  input  1  single-cycle request to begin a program run from PC 0
- stall  input  1  hold PC and state this cycle
- instr  input  IW  instruction read combinationally from imem at pc
- uncond_jump  input  1  decoder: unconditional jump
- jtype  input  1  decoder: jump-class instruction
- flag_eq, flag_lt, flag_gt  input  1 each  registered compare flags from last cmp
- pc  output  PCW  current program counter (registered)
- done  output  1  high while in HALT (registered)
- running  output  1  high while in RUN (registered)
- cycle_cnt  output  CNTW  count of non-stalled RUN cycles, saturating

## Operation
- States: IDLE, RUN, HALT.
- Reset state: IDLE, pc=0, done=0, running=0, cycle_cnt=0.
- IDLE:
  - start=1 → RUN, pc=0, cycle_cnt=0.
  - Otherwise hold; instr is ignored.
- RUN, stall=1: all registers hold; the halt opcode and jumps are not acted on.
- RUN, stall=0: cycle_cnt increments, saturating at 2^CNTW-1. Next PC:
  - Opcode 4'b1111 (HALT): → HALT, pc holds.
  - taken = uncond_jump | (jtype & cond). cond by opcode:
    - 0001 → flag_eq
    - 0010 → !flag_eq
    - 0011 → flag_lt
    - 0100 → flag_gt
    - any other opcode → 0
  - taken: pc = lut[instr[4:0]].
  - Otherwise: pc = pc+1, wrapping from 2^PCW-1 to 0.
- HALT: done=1, pc and cycle_cnt frozen; start=1 → RUN, pc=0, cycle_cnt=0, done=0.
- start in RUN is ignored.
- reset together with start: reset wins.
- reset mid-run: IDLE on the next edge; no partial update.
- Default LUT contents: lut[i] = (i*10) mod 2^PCW.

## Timing
- pc is registered. instr is valid in the same cycle as pc (combinational imem). The next-PC decision is made that cycle and takes effect at the next edge.
- Jump latency is 1 cycle, with no delay slot. The instruction after a taken jump is never fetched.
- Flags are sampled in the cycle the jump instruction is at pc, so a cmp immediately preceding the jump must have updated the flags by that edge.
- done and running change at the edge that enters or leaves their state: done rises the cycle after HALT is fetched.
- start→RUN takes 1 cycle: the first instruction (pc=0) is presented in the cycle after start is sampled.

## Structure
- Package fetch_pkg holds:
  - the state enum (IDLE, RUN, HALT);
  - opcode constants OP_JMP=0000, OP_BEQ=0001, OP_BNE=0010, OP_BLT=0011, OP_BGT=0100, OP_HALT=1111;
  - parameter defaults.
- Sub-module jump_lut: combinational, 5-bit index in, PCW-bit target out, holding the 32-entry table. It is kept separate so the assembler team can regenerate it.
- fetch_ctrl contains the FSM, PC register, condition mux and cycle counter.

## Test plan
- Reset: assert reset 2 cycles with random start/instr → pc=0, done=0, running=0, cycle_cnt=0; without start, pc stays 0 for 10 cycles.
- Linear run: start pulse, then 5 ALU opcodes (0101) → pc 0,1,2,3,4,5 on successive cycles; cycle_cnt=5.
- Unconditional jump: at pc=2, opcode 0000 with uncond_jump=1, index 3 → next pc=30.
- Conditional jumps:
  - BEQ index 1: flag_eq=0 → pc+1; flag_eq=1 → pc=10.
  - BNE, BLT, BGT each taken/not taken.
  - jtype=1 with opcode 0101 → pc+1.
- Halt and restart:
  - HALT at pc=7 → next cycle done=1, pc=7; cycle_cnt frozen for 5 cycles.
  - start → next cycle pc=0, done=0, running=1.
- Stall, wrap, reset:
  - stall=1 for 3 cycles with HALT at pc → pc holds, done stays 0; done=1 the cycle after stall drops.
  - pc=1023 with a non-jump instruction → pc=0.
  - reset mid-run at pc=12 → next cycle IDLE, pc=0.
